// File: rtl/bridge_fifo_leaf.sv
// Bridge leaf: 4-word register window feeding a first-word-fall-through FIFO drained by a valid/ready stream.
// Latency: bridge read data registered one cycle after bridge_rd; a DATA push is visible on out_valid/out_data one cycle later.
// Backpressure: out_ready stalls the stream; a push into a full FIFO without a same-cycle pop is dropped and sets overflow.
module bridge_fifo_leaf #(
   parameter logic [31:0] ADDR_BASE = 32'h0000_1000,
   parameter int          DEPTH     = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [31:0]                bridge_addr,
   input  logic [31:0]                bridge_wr_data,
   input  logic                       bridge_wr,
   input  logic                       bridge_rd,
   output logic [31:0]                bridge_rd_data,
   output logic [31:0]                out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_CONTROL = 2'd2;
   localparam logic [1:0] REG_COUNT   = 2'd3;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [31:0]   push_count;

   logic          hit;
   logic [1:0]    sel;
   logic          wr_hit;
   logic          push_req;
   logic          flush;
   logic          ovf_clr;
   logic          cnt_clr;
   logic          pop;
   logic          full;
   logic          push_ok;
   logic          drop;
   logic [31:0]   status_word;

   // Byte-lane bits are don't-care within a 32-bit register.
   logic [1:0]    unused_addr_lsb;
   assign unused_addr_lsb = bridge_addr[1:0];

   // Window decode and per-register write strobes.
   always_comb begin
      hit      = (bridge_addr[31:4] == ADDR_BASE[31:4]);
      sel      = bridge_addr[3:2];
      wr_hit   = bridge_wr & hit;
      push_req = wr_hit & (sel == REG_DATA);
      flush    = wr_hit & (sel == REG_CONTROL) & bridge_wr_data[0];
      ovf_clr  = wr_hit & (sel == REG_STATUS) & bridge_wr_data[31];
      cnt_clr  = wr_hit & (sel == REG_COUNT);
      full     = (level == LW'(DEPTH));
      pop      = out_valid & out_ready;
      // A pop in the same cycle frees the slot the push needs.
      push_ok  = push_req & (~full | pop);
      drop     = push_req & full & ~pop;
   end

   assign out_valid   = (level != '0);
   assign out_data    = mem[rd_ptr];
   assign status_word = {overflow, {(31-LW){1'b0}}, level};

   // Storage array; pointers alone define validity, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (!reset && push_ok) begin
         mem[wr_ptr] <= bridge_wr_data;
      end
   end

   // Pointers, fill level, sticky overflow and accepted-push counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         overflow   <= 1'b0;
         push_count <= '0;
      end else if (flush) begin
         // Flush beats any same-cycle pop; the counter is left alone.
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push_ok && !pop) begin
            level <= level + LW'(1);
         end else if (pop && !push_ok) begin
            level <= level - LW'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
         if (cnt_clr) begin
            push_count <= '0;
         end else if (push_ok) begin
            push_count <= push_count + 32'd1;
         end
      end
   end

   // Registered read port; returns pre-update state and zero outside the window.
   always_ff @(posedge clk) begin
      if (reset) begin
         bridge_rd_data <= '0;
      end else if (bridge_rd) begin
         if (hit && sel == REG_STATUS) begin
            bridge_rd_data <= status_word;
         end else if (hit && sel == REG_COUNT) begin
            bridge_rd_data <= push_count;
         end else begin
            bridge_rd_data <= '0;
         end
      end
   end

endmodule

// File: doc/bridge_fifo_leaf.md
Name: bridge_fifo_leaf

Overview:
Leaf stage on the APF bridge tree. It decodes a 4-word address window and pushes host writes to the DATA word into a first-word-fall-through FIFO. Core logic drains the FIFO through a valid/ready stream. Status, flush and word-count registers are readable and writable over the bridge. Read data is zero outside the window, so parent tree nodes can OR leaf rd_data together.

Parameters:
- ADDR_BASE, 32'h0000_1000: byte address of the window. Must be 16-byte aligned.
- DEPTH, 16: FIFO depth in 32-bit words. Power of 2, minimum 2.

Ports:
- clk, input, 1: bridge/core clock.
- reset, input, 1: synchronous, active-high.
- bridge_addr, input, 32: bridge byte address.
- bridge_wr_data, input, 32: bridge write data.
- bridge_wr, input, 1: one-cycle write strobe.
- bridge_rd, input, 1: one-cycle read strobe.
- bridge_rd_data, output, 32: registered read data.
- out_data, output, 32: FIFO head word. Valid while out_valid=1.
- out_valid, output, 1: FIFO not empty.
- out_ready, input, 1: consumer accepts the head word.
- level, output, $clog2(DEPTH)+1: current fill count.
- overflow, output, 1: sticky flag, set when a write is dropped.

Behaviour:
- Window decode: hit when bridge_addr[31:4] == ADDR_BASE[31:4]. Register select is addr[3:2]; addr[1:0] is ignored.
- Register map:
  - 0x0 DATA: write pushes wr_data. Read returns 0.
  - 0x4 STATUS: read returns {overflow, 0s, level}, with overflow at bit31 and level in the LSBs. Write with bit31=1 clears overflow; other bits are ignored.
  - 0x8 CONTROL: write with bit0=1 flushes the FIFO: level=0, read/write pointers=0, overflow=0. Read returns 0.
  - 0xC COUNT: read returns a 32-bit count of accepted pushes, wrapping modulo 2^32. Any write clears it to 0.
- Reset values: bridge_rd_data=0, out_valid=0, level=0, overflow=0, COUNT=0, pointers=0. out_data is don't-care while out_valid=0.
- Read latency:
  - bridge_rd at cycle N loads bridge_rd_data at the N+1 edge, using pre-update state from cycle N.
  - The value holds until the next bridge_rd.
  - A bridge_rd that misses the window loads 0.
- Write latency: a DATA push at cycle N raises out_valid at N+1 if the FIFO was empty. No combinational wr-to-out path.
- Pop: occurs on any cycle with out_valid & out_ready. out_data then advances to the next word at the next edge. FWFT: out_data always shows the head word.
- Full (level==DEPTH):
  - Push with no pop in the same cycle is dropped: overflow<=1, COUNT unchanged.
  - Push with a pop in the same cycle is accepted; level stays DEPTH.
- Empty: out_ready is ignored. Simultaneous push and empty is a normal push; level becomes 1.
- Push and pop in the same cycle otherwise: level unchanged, COUNT+1.
- Flush priority:
  - A flush write has priority over any same-cycle pop.
  - Only one bridge write exists per cycle, so flush and push never coincide.
  - After a flush, out_valid=0 at the next edge.
- Overflow-clear write: cannot coincide with a dropped push (single write per cycle). Clear takes effect at the next edge.
- Simultaneous bridge_rd and bridge_wr: both are processed. The read returns pre-write state.
- Reset mid-operation: all state returns to reset values at that edge, and stored data is discarded. A bridge_rd asserted during reset returns 0.
- Pointers: width $clog2(DEPTH), wrap naturally. Level is tracked as a separate counter. Storage is register or LUT-RAM array with an asynchronous read at the read pointer.

Test Plan:
- Reset, then read STATUS (0x1004) -> rd_data=0 one cycle after rd; out_valid=0.
- Write 0xA5A5_0001, 0xA5A5_0002, 0xA5A5_0003 to 0x1000 with out_ready=0 -> level=3, STATUS reads 0x0000_0003. Raise out_ready -> out_data emits 0x…01, 0x…02, 0x…03 on consecutive cycles, then out_valid=0. COUNT reads 3.
- Fill 16 words, then write 0xDEAD_BEEF with out_ready=0 -> word dropped, STATUS reads 0x8000_0010, COUNT=16. Write 0x8000_0000 to STATUS -> reads 0x0000_0010.
- FIFO full; push 0x1234_5678 in the same cycle as a pop -> accepted, level stays 16, overflow=0. The last word drained is 0x1234_5678.
- Load 5 words, write 1 to CONTROL (0x1008) while out_ready=1 -> next cycle level=0, out_valid=0. Read of 0x2000 (outside window) -> rd_data=0.
- Push 3 words, assert reset for one cycle -> level=0, COUNT=0, bridge_rd_data=0. A subsequent push of 0x0000_0042 appears as out_data=0x42.
